// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, the latched request payload and the request error check.
package data_mem_responder_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BE_W       = WORD_BYTES;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [BE_W-1:0]   byte_en;
  } mem_req_t;

  // Misaligned byte address, or word index beyond the array.
  function automatic logic req_error(input logic [ADDR_W-1:0] addr,
                                     input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr[ADDR_W-1:2] >= 30'(depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-wide synchronous single-port RAM with per-byte write enables.
// Read data is registered and returns to zero on any cycle without a read.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BE_W-1:0]   we,
  input  logic              rd_en,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(BE_W); k++) begin
      if (we[k]) begin
        mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store path: one request at a time,
// WAIT_CYCLES wait states, then a single-cycle response with data or error.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_memWrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_writeData,
  input  logic [BE_W-1:0]   i_byteEn,
  output logic              o_rspValid,
  output logic [DATA_W-1:0] o_readData,
  output logic              o_error
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_d;
  mem_req_t           req_q;
  mem_req_t           req_in;
  mem_req_t           cur_req;
  logic               accept;
  logic               commit;
  logic               cur_err;
  logic [BE_W-1:0]    ram_we;
  logic               ram_rd_en;
  logic [AW-1:0]      ram_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // live request is used in IDLE instead of the (not yet loaded) latch.
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    accept     = 1'b0;
    req_in     = '{mem_write:  i_memWrite,
                   addr:       i_addr,
                   write_data: i_writeData,
                   byte_en:    i_byteEn};
    cur_req    = req_q;
    case (state)
      IDLE: begin
        cur_req = req_in;
        if (i_req) begin
          accept     = 1'b1;
          cnt_d      = CNT_W'(WAIT_CYCLES);
          next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    commit    = (next_state == RESP) && !i_rst;
    cur_err   = req_error(cur_req.addr, DEPTH);
    ram_we    = (commit && cur_req.mem_write && !cur_err) ? cur_req.byte_en : '0;
    ram_rd_en = commit && !cur_req.mem_write && !cur_err;
    ram_idx   = cur_req.addr[AW+1:2];
  end

  // Handshake/response flags mirror the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      req_q      <= '0;
      o_ready    <= 1'b1;
      o_rspValid <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      if (accept) begin
        req_q <= req_in;
      end
      o_ready    <= (next_state == IDLE);
      o_rspValid <= (next_state == RESP);
      o_error    <= commit && cur_err;
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (ram_we),
    .rd_en (ram_rd_en),
    .idx   (ram_idx),
    .wdata (cur_req.write_data),
    .rdata (o_readData)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three builds (0, 1 and 3 wait states) checked
// every cycle against a transaction-level memory model, plus literal pins.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam int NL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [NL];
  logic        req   [NL];
  logic        rdy   [NL];
  logic        we    [NL];
  logic [31:0] addr  [NL];
  logic [31:0] wdata [NL];
  logic [3:0]  be    [NL];
  logic        rsp   [NL];
  logic [31:0] rdata [NL];
  logic        err   [NL];

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .i_clk(clk), .i_rst(rst[0]), .i_req(req[0]), .o_ready(rdy[0]),
    .i_memWrite(we[0]), .i_addr(addr[0]), .i_writeData(wdata[0]), .i_byteEn(be[0]),
    .o_rspValid(rsp[0]), .o_readData(rdata[0]), .o_error(err[0]));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
    .i_clk(clk), .i_rst(rst[1]), .i_req(req[1]), .o_ready(rdy[1]),
    .i_memWrite(we[1]), .i_addr(addr[1]), .i_writeData(wdata[1]), .i_byteEn(be[1]),
    .o_rspValid(rsp[1]), .o_readData(rdata[1]), .o_error(err[1]));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .i_clk(clk), .i_rst(rst[2]), .i_req(req[2]), .o_ready(rdy[2]),
    .i_memWrite(we[2]), .i_addr(addr[2]), .i_writeData(wdata[2]), .i_byteEn(be[2]),
    .o_rspValid(rsp[2]), .o_readData(rdata[2]), .o_error(err[2]));

  // Reference model: memory image plus the single outstanding transaction.
  logic [31:0] ref_mem  [NL][DEPTH];
  bit          pend_v   [NL];
  int          pend_acc [NL];
  int          pend_due [NL];
  logic        pend_we  [NL];
  logic [31:0] pend_addr[NL];
  logic [31:0] pend_data[NL];
  logic [3:0]  pend_be  [NL];
  bit          started  [NL];
  int          acc_cnt  [NL];
  int          rsp_cnt  [NL];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wl(input int l);
    case (l)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit model_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: handshake did not complete within budget (cycle %0d)", nm, cyc);
  endtask

  // Per-cycle compare against the model, then model update for this edge.
  always @(negedge clk) begin
    bit ev, ee, erdy;
    logic [31:0] ed;
    int idx;
    for (int l = 0; l < NL; l++) begin
      erdy = 1'b1;
      if (started[l]) begin
        ev   = pend_v[l] && (cyc == pend_due[l]);
        erdy = !(pend_v[l] && (cyc >= pend_acc[l]));
        ee   = 1'b0;
        ed   = 32'h0;
        idx  = int'(pend_addr[l] / 4);
        if (ev) begin
          ee = model_err(pend_addr[l]);
          if (!pend_we[l] && !ee) ed = ref_mem[l][idx];
        end
        chk($sformatf("lane%0d_ready", l), {31'b0, rdy[l]}, {31'b0, erdy});
        chk($sformatf("lane%0d_rsp_valid", l), {31'b0, rsp[l]}, {31'b0, ev});
        chk($sformatf("lane%0d_error", l), {31'b0, err[l]}, {31'b0, ee});
        chk($sformatf("lane%0d_read_data", l), rdata[l], ed);
        if (ev) begin
          if (pend_we[l] && !ee) begin
            for (int k = 0; k < 4; k++)
              if (pend_be[l][k]) ref_mem[l][idx][8*k +: 8] = pend_data[l][8*k +: 8];
          end
          pend_v[l] = 1'b0;
          rsp_cnt[l]++;
        end
      end
      if (rst[l]) begin
        pend_v[l]  = 1'b0;
        started[l] = 1'b1;
      end else if (started[l] && req[l] && erdy) begin
        pend_v[l]    = 1'b1;
        pend_acc[l]  = cyc + 1;
        pend_due[l]  = cyc + 1 + wl(l);
        pend_we[l]   = we[l];
        pend_addr[l] = addr[l];
        pend_data[l] = wdata[l];
        pend_be[l]   = be[l];
        acc_cnt[l]++;
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  task automatic rand_fields(input int l);
    we[l]    = 1'($urandom_range(0, 1));
    addr[l]  = rand_addr();
    wdata[l] = $urandom;
    be[l]    = 4'($urandom_range(0, 15));
  endtask

  task automatic do_req(input int l, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input bit junk,
                        output logic [31:0] rd, output logic re, output int lat);
    int acyc;
    bit ok;
    rd = '0; re = 1'b0; lat = -1; acyc = 0;
    @(posedge clk); #1;
    req[l] = 1'b1; we[l] = w; addr[l] = a; wdata[l] = d; be[l] = b;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rdy[l]) begin ok = 1'b1; acyc = cyc; end
    end
    if (!ok) begin
      timeout($sformatf("lane%0d_accept", l));
      req[l] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (junk) begin
      addr[l] = a ^ 32'h4; wdata[l] = ~d;
      repeat (wl(l)) begin @(posedge clk); #1; end
    end
    req[l] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rsp[l]) begin ok = 1'b1; rd = rdata[l]; re = err[l]; lat = cyc - acyc; end
    end
    if (!ok) timeout($sformatf("lane%0d_response", l));
  endtask

  // Store accepted, then reset pulsed during the second wait-state cycle.
  task automatic rst_store(input int l, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    @(posedge clk); #1;
    req[l] = 1'b1; we[l] = 1'b1; addr[l] = a; wdata[l] = d; be[l] = 4'hF;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rdy[l]) ok = 1'b1;
    end
    if (!ok) begin timeout("rst_store_accept"); req[l] = 1'b0; return; end
    @(posedge clk); #1; req[l] = 1'b0;
    @(posedge clk); #1; rst[l] = 1'b1;
    @(posedge clk); #1; rst[l] = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", {31'b0, rdy[l]}, 32'h1);
    chk("rst_no_rsp", {31'b0, rsp[l]}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        re;
  int          lat;
  int          a0, r0;

  initial begin
    for (int l = 0; l < NL; l++) begin
      rst[l] = 1'b1; req[l] = 1'b0; we[l] = 1'b0;
      addr[l] = '0; wdata[l] = '0; be[l] = '0;
      pend_v[l] = 1'b0; started[l] = 1'b0; acc_cnt[l] = 0; rsp_cnt[l] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) rst[l] = 1'b0;
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("reset_ready%0d", l), {31'b0, rdy[l]}, 32'h1);
      chk($sformatf("reset_rsp%0d", l), {31'b0, rsp[l]}, 32'h0);
      chk($sformatf("reset_rdata%0d", l), rdata[l], 32'h0);
      chk($sformatf("reset_err%0d", l), {31'b0, err[l]}, 32'h0);
    end

    for (int l = 0; l < NL; l++)
      for (int i = 0; i < int'(DEPTH); i++)
        do_req(l, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, rd, re, lat);

    // Directed cases on the single-wait-state build.
    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, re, lat);
    chk("st10_latency", 32'(lat), 32'd2);
    chk("st10_err", {31'b0, re}, 32'h0);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, re, lat);
    chk("ld10_data", rd, 32'hDEADBEEF);
    chk("ld10_err", {31'b0, re}, 32'h0);
    chk("ld10_latency", 32'(lat), 32'd2);
    do_req(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd, re, lat);
    do_req(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd, re, lat);
    do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, re, lat);
    chk("ld20_merge", rd, 32'h11BB33DD);
    do_req(1, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0, rd, re, lat);
    chk("ld22_misalign_err", {31'b0, re}, 32'h1);
    chk("ld22_misalign_data", rd, 32'h0);
    do_req(1, 1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 1'b0, rd, re, lat);
    chk("ld_oor_err", {31'b0, re}, 32'h1);
    chk("ld_oor_data", rd, 32'h0);
    do_req(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, rd, re, lat);
    do_req(1, 1'b1, 32'(DEPTH * 4), 32'h55555555, 4'hF, 1'b0, rd, re, lat);
    chk("st_oor_err", {31'b0, re}, 32'h1);
    do_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, re, lat);
    chk("ld0_after_oor_store", rd, 32'h0BADF00D);
    do_req(1, 1'b1, 32'h30, 32'h01020304, 4'hF, 1'b0, rd, re, lat);
    do_req(1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 1'b0, rd, re, lat);
    chk("st_be0_err", {31'b0, re}, 32'h0);
    do_req(1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, rd, re, lat);
    chk("ld30_after_be0", rd, 32'h01020304);

    // Zero-wait build with the request held continuously for 60 cycles.
    a0 = acc_cnt[0];
    r0 = rsp_cnt[0];
    @(posedge clk); #1;
    req[0] = 1'b1;
    repeat (60) begin
      rand_fields(0);
      @(posedge clk); #1;
    end
    req[0] = 1'b0;
    repeat (3) @(posedge clk);
    chk("w0_accepts", 32'(acc_cnt[0] - a0), 32'd30);
    chk("w0_responses", 32'(rsp_cnt[0] - r0), 32'd30);

    // Reset during wait states discards the store.
    do_req(2, 1'b1, 32'h24, 32'h12345678, 4'hF, 1'b0, rd, re, lat);
    rst_store(2, 32'h24, 32'hCAFEF00D);
    do_req(2, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, rd, re, lat);
    chk("ld24_after_reset", rd, 32'h12345678);
    chk("ld24_latency", 32'(lat), 32'd4);

    // Requests presented during wait states must be ignored.
    do_req(2, 1'b1, 32'h08, 32'hA5A5F00F, 4'hF, 1'b1, rd, re, lat);
    do_req(2, 1'b0, 32'h08, 32'h0, 4'h0, 1'b1, rd, re, lat);
    chk("ld08_junk_ignored", rd, 32'hA5A5F00F);
    do_req(2, 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, rd, re, lat);

    for (int l = 0; l < NL; l++) begin
      for (int n = 0; n < 120; n++) begin
        rand_fields(l);
        do_req(l, we[l], addr[l], wdata[l], be[l], ($urandom_range(0, 7) == 0),
               rd, re, lat);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
